mcpu_cu_ext: RTL

Parametrised successor to the multicycle CPU control unit. A Moore-style FSM sequences the datapath through fetch, decode, memory, execute and write-back. It adds ADDI, BNE, JAL and JR, a memory-ready wait handshake, an instruction-retire strobe and illegal-opcode detection. It sits between the instruction register's op/func fields and the multicycle datapath's mux selects and write enables.

---
 rtl/mcpu_pkg.sv | 83 ++++++++
 rtl/mcpu_op_decode.sv | 43 ++++
 rtl/mcpu_cu_ext.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the extended multicycle CPU control unit:
// opcode/func constants, FSM state encoding, datapath select encodings.
package mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_JMP     = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_BNE     = 4'd14
    } state_t;

    typedef enum logic [1:0] {MTOR_ALU = 2'b00, MTOR_MDR = 2'b01, MTOR_PC = 2'b10} mtor_e;
    typedef enum logic [1:0] {RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_R31 = 2'b10} rdst_e;
    typedef enum logic [1:0] {ALUB_B = 2'b00, ALUB_4 = 2'b01, ALUB_IMM = 2'b10, ALUB_IMM_SH = 2'b11} alub_e;
    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNC = 2'b10} aluop_e;
    typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_T = 2'b01, PCS_JUMP = 2'b10, PCS_REGA = 2'b11} pcs_e;

    // One-hot instruction class produced by the decoder.
    typedef struct packed {
        logic mem;
        logic rtype;
        logic jr;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic addi;
        logic illegal;
    } instr_class_t;

    typedef struct packed {
        logic   pcw;
        logic   pcwc;
        logic   brne;
        logic   iord;
        logic   mr;
        logic   mw;
        logic   irw;
        logic   regw;
        logic   alusela;
        logic   tw;
        mtor_e  mtor;
        rdst_e  rdst;
        alub_e  aluselb;
        aluop_e aluop;
        pcs_e   pcs;
        logic   instr_done;
        logic   illegal;
    } ctrl_t;

    // Address computation shared by MEMADR, MEMRD and MEMWR.
    function automatic ctrl_t ctrl_memadr();
        ctrl_t c;
        c         = '0;
        c.alusela = 1'b1;
        c.aluselb = ALUB_IMM;
        c.iord    = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mcpu_op_decode.sv
// Combinational op/func decoder: maps the instruction fields to a one-hot
// instruction class; extended ops fold into the illegal class when disabled.
module mcpu_op_decode
    import mcpu_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                if (func == FN_JR) begin
                    if (EXT_OPS) cls.jr      = 1'b1;
                    else         cls.illegal = 1'b1;
                end else begin
                    cls.rtype = 1'b1;
                end
            end
            OP_LW, OP_SW: cls.mem = 1'b1;
            OP_BEQ:       cls.beq = 1'b1;
            OP_J:         cls.j   = 1'b1;
            OP_BNE: begin
                if (EXT_OPS) cls.bne     = 1'b1;
                else         cls.illegal = 1'b1;
            end
            OP_JAL: begin
                if (EXT_OPS) cls.jal     = 1'b1;
                else         cls.illegal = 1'b1;
            end
            OP_ADDI: begin
                if (EXT_OPS) cls.addi    = 1'b1;
                else         cls.illegal = 1'b1;
            end
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcpu_cu_ext.sv
// Moore-style multicycle CPU control unit with ADDI/BNE/JAL/JR, memory-ready
// wait states, a retire strobe and illegal-opcode detection.
module mcpu_cu_ext
    import mcpu_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_OPS     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_rdy,
    output logic       pcw,
    output logic       pcwc,
    output logic       brne,
    output logic       iord,
    output logic       mr,
    output logic       mw,
    output logic       irw,
    output logic       regw,
    output logic       alusela,
    output logic       tw,
    output logic [1:0] mtor,
    output logic [1:0] rdst,
    output logic [1:0] aluselb,
    output logic [1:0] aluop,
    output logic [1:0] pcs,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t       state_q;
    state_t       state_d;
    logic         is_lw_q;
    logic         rdy;
    instr_class_t cls;
    ctrl_t        c;
    ctrl_t        ctrl;

    assign rdy = MEM_WAIT_EN ? mem_rdy : 1'b1;

    mcpu_op_decode #(.EXT_OPS(EXT_OPS)) u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset branch must be the first test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // LW/SW direction is latched in DECODE so later op changes are ignored.
            if (state_q == S_DECODE) is_lw_q <= (op == OP_LW);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        c       = '0;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                c.mr      = 1'b1;
                c.aluselb = ALUB_4;
                c.irw     = rdy;
                c.pcw     = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.aluselb = ALUB_IMM_SH;
                c.tw      = 1'b1;
                c.illegal = cls.illegal;
                if      (cls.mem)   state_d = S_MEMADR;
                else if (cls.rtype) state_d = S_EXEC;
                else if (cls.jr)    state_d = S_JR;
                else if (cls.beq)   state_d = S_BEQ;
                else if (cls.bne)   state_d = S_BNE;
                else if (cls.j)     state_d = S_JMP;
                else if (cls.addi)  state_d = S_ADDI_EX;
                else if (cls.jal)   state_d = S_JAL;
                else                state_d = S_FETCH;
            end
            S_MEMADR: begin
                c       = ctrl_memadr();
                state_d = is_lw_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c       = ctrl_memadr();
                c.mr    = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c.mtor       = MTOR_MDR;
                c.rdst       = RDST_RT;
                c.regw       = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c            = ctrl_memadr();
                c.mw         = 1'b1;
                c.instr_done = rdy;
                state_d      = rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC, S_ALUWB: begin
                c.alusela = 1'b1;
                c.aluop   = ALUOP_FUNC;
                if (state_q == S_ALUWB) begin
                    c.rdst       = RDST_RD;
                    c.regw       = 1'b1;
                    c.instr_done = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_BEQ, S_BNE: begin
                c.alusela    = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pcwc       = 1'b1;
                c.pcs        = PCS_T;
                c.brne       = (state_q == S_BNE);
                c.instr_done = 1'b1;
            end
            S_JMP: begin
                c.pcw        = 1'b1;
                c.pcs        = PCS_JUMP;
                c.instr_done = 1'b1;
            end
            S_ADDI_EX, S_ADDI_WB: begin
                c.alusela = 1'b1;
                c.aluselb = ALUB_IMM;
                if (state_q == S_ADDI_WB) begin
                    c.regw       = 1'b1;
                    c.instr_done = 1'b1;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_JAL: begin
                // PC already holds PC+4, which is what gets linked into $31.
                c.pcw        = 1'b1;
                c.pcs        = PCS_JUMP;
                c.regw       = 1'b1;
                c.rdst       = RDST_R31;
                c.mtor       = MTOR_PC;
                c.instr_done = 1'b1;
            end
            S_JR: begin
                c.pcw        = 1'b1;
                c.pcs        = PCS_REGA;
                c.instr_done = 1'b1;
            end
            default: begin
                c       = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low during reset so no memory or PC write can occur.
    assign ctrl    = rst_n ? c : '0;
    assign state_o = rst_n ? state_q : 4'd0;

    assign pcw        = ctrl.pcw;
    assign pcwc       = ctrl.pcwc;
    assign brne       = ctrl.brne;
    assign iord       = ctrl.iord;
    assign mr         = ctrl.mr;
    assign mw         = ctrl.mw;
    assign irw        = ctrl.irw;
    assign regw       = ctrl.regw;
    assign alusela    = ctrl.alusela;
    assign tw         = ctrl.tw;
    assign mtor       = ctrl.mtor;
    assign rdst       = ctrl.rdst;
    assign aluselb    = ctrl.aluselb;
    assign aluop      = ctrl.aluop;
    assign pcs        = ctrl.pcs;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;

endmodule
